// File: rtl/boot_loader.sv
// Boot loader: receives a byte stream (header N, N data words, optional checksum),
// writes the words to memory and releases the CPU reset. Optional checksum: BOOT_CHECKSUM_EN.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [1:0]         byte_cnt;
  logic [23:0]        shift;
  logic [IDX_W-1:0]   n_words;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               last_byte;
  logic [31:0]        word;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]        sum;
`endif

  // Terminal states and WRITE never take bytes, so ready depends on state alone.
`ifdef BOOT_CHECKSUM_EN
  assign in_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
`else
  assign in_ready  = (state == S_HDR) || (state == S_DATA);
`endif
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign word      = {shift, in_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_HDR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HDR: begin
        if (last_byte)
          next_state = ((word == 32'd0) || (word > 32'(MAX_WORDS))) ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (last_byte) next_state = S_WRITE;
      end
      S_WRITE: begin
        if ((idx + IDX_W'(1)) < n_words) next_state = S_DATA;
`ifdef BOOT_CHECKSUM_EN
        else                             next_state = S_CSUM;
`else
        else                             next_state = S_DONE;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (last_byte) next_state = (word == sum) ? S_DONE : S_ERR;
      end
`endif
      default: next_state = state;
    endcase
  end

  // Status outputs are registered from next_state so they change cleanly with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= 2'd0;
      shift     <= 24'd0;
      n_words   <= '0;
      idx       <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'd0;
      mem_write <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum       <= 32'd0;
`endif
    end else begin
      if (accept) begin
        shift    <= word[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end
      if ((state == S_HDR) && last_byte) begin
        n_words <= word[IDX_W-1:0];
        idx     <= '0;
      end
      if ((state == S_DATA) && last_byte) begin
        mem_wdata <= word;
        mem_addr  <= BASE_ADDR + (32'(idx) << 2);
      end
      if (state == S_WRITE) begin
        idx <= idx + IDX_W'(1);
`ifdef BOOT_CHECKSUM_EN
        sum <= sum + mem_wdata;
`endif
      end
      mem_write <= (next_state == S_WRITE);
      done      <= (next_state == S_DONE);
      error     <= (next_state == S_ERR);
      cpu_reset <= (next_state != S_DONE);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader; each task drives one scenario and checks inline.
// Build with BOOT_CHECKSUM_EN defined to exercise the checksum path as well.
module tb_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int total = 0;
  int bad = 0;
  logic [63:0] wr_q[$];

  boot_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Record every memory write as {addr, data}, sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_write === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) begin
      total++; bad++;
      $display("FAIL send_timeout: byte %h never accepted (in_ready=%b)", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wr_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) @(negedge clock);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 00000000", mem_wdata); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
    in_valid = 1'b0;
    reset    = 1'b1;
    wr_q.delete();
    @(negedge clock);
  endtask

  // Runs straight after test_reset, so any byte captured while in reset corrupts this image.
  task automatic test_basic();
    send_word(32'd2);
    send_word(32'h1234_5678);
    send_word(32'h9ABC_DEF0);
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL basic_write_latency: got %b want 1", mem_write); end
    total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL basic_last_addr: got %h want 00000004", mem_addr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early: got %b want 0", done); end
`ifdef BOOT_CHECKSUM_EN
    send_word(32'hACF1_3568);
`else
    @(negedge clock);
`endif
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", done); end
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL basic_cpu_reset: got %b want 0", cpu_reset); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", error); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL basic_write_pulse: got %b want 0", mem_write); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done: got %b want 0", in_ready); end
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL basic_write_count: got %0d want 2", wr_q.size()); end
    if (wr_q.size() >= 2) begin
      total++; if (wr_q[0] !== 64'h0000_0000_1234_5678) begin bad++; $display("FAIL basic_write0: got %h want 0000000012345678", wr_q[0]); end
      total++; if (wr_q[1] !== 64'h0000_0004_9ABC_DEF0) begin bad++; $display("FAIL basic_write1: got %h want 000000049abcdef0", wr_q[1]); end
    end
    repeat (3) @(negedge clock);
    total++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin bad++; $display("FAIL basic_done_hold: got done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
  endtask

  task automatic test_empty();
    do_reset();
    send_word(32'd0);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL empty_error: got %b want 1", error); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL empty_cpu_reset: got %b want 1", cpu_reset); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL empty_done: got %b want 0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL empty_ready: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    total++; if (error !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL empty_terminal: got error=%b in_ready=%b want 1/0", error, in_ready); end
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL empty_no_write: got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_oversize();
    do_reset();
    send_word(32'd65);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL oversize_error: got %b want 1", error); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL oversize_cpu_reset: got %b want 1", cpu_reset); end
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL oversize_no_write: got %0d want 0", wr_q.size()); end
    do_reset();
    send_word(32'd64);
    total++; if (error !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL max_words_accept: got error=%b in_ready=%b want 0/1", error, in_ready); end
    do_reset();
    send_word(32'h0100_0001);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL oversize_high_bits: got %b want 1", error); end
  endtask

  task automatic test_gaps();
    logic [31:0] w;
    do_reset();
    send_word(32'd1);
    w = 32'hA1B2_C3D4;
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      @(negedge clock);
    end
`ifdef BOOT_CHECKSUM_EN
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      @(negedge clock);
    end
`endif
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL gaps_write_count: got %0d want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      total++; if (wr_q[0] !== 64'h0000_0000_A1B2_C3D4) begin bad++; $display("FAIL gaps_write: got %h want 00000000a1b2c3d4", wr_q[0]); end
    end
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL gaps_done: got done=%b error=%b want 1/0", done, error); end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_word(32'd3);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL midload_ready_write: got %b/%b want 1/0", in_ready, mem_write); end
    total++; if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL midload_status: got cpu_reset=%b done=%b error=%b want 1/0/0", cpu_reset, done, error); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL midload_mem: got %h/%h want 00000000/00000000", mem_addr, mem_wdata); end
    @(negedge clock);
    reset = 1'b1;
    wr_q.delete();
    send_word(32'd1);
    send_word(32'h5566_7788);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'h5566_7788);
`else
    @(negedge clock);
`endif
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL reload_write_count: got %0d want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      total++; if (wr_q[0] !== 64'h0000_0000_5566_7788) begin bad++; $display("FAIL reload_write: got %h want 0000000055667788", wr_q[0]); end
    end
    total++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin bad++; $display("FAIL reload_done: got done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    send_word(32'd2);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0000);
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL csum_good: got done=%b error=%b want 1/0", done, error); end
    do_reset();
    send_word(32'd2);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0001);
    total++; if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL csum_bad: got error=%b done=%b want 1/0", error, done); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL csum_bad_cpu_reset: got %b want 1", cpu_reset); end
  endtask
`endif

  initial begin
    $display("[TB] boot_loader directed test start");
    test_reset();
    test_basic();
    test_empty();
    test_oversize();
    test_gaps();
    test_reset_midload();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
